// File: rtl/ser_input_ctrlr.sv
// ser_input_ctrlr: serial frame receiver (start 1, DATA_W bits MSB first, stop 0)
// Ports:
//   clk_div_4      sampling clock, one line bit per rising edge
//   reset_n        asynchronous active-low reset
//   ser_in         serial line, idle low
//   rx_enable      allows start detection; dropping it mid-frame aborts the frame
//   data_ack       consumer accepts the held word
//   clr_flags      clears the sticky error flags
//   data_in        last complete received word
//   valid_data_in  data_in holds an unacknowledged word
//   busy           frame reception in progress
//   frame_err      sticky, stop bit sampled as 1
//   overrun        sticky, good word dropped while the held word was unacknowledged
module ser_input_ctrlr #(
  parameter int DATA_W = 64
) (
  input  logic              clk_div_4,
  input  logic              reset_n,
  input  logic              ser_in,
  input  logic              rx_enable,
  input  logic              data_ack,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] data_in,
  output logic              valid_data_in,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] shift_reg, shift_n, data_n;
  logic valid_n, fe_n, ov_n;
  always_ff @(posedge clk_div_4 or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      shift_reg <= '0;
      data_in <= '0;
      valid_data_in <= 1'b0;
      busy <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shift_reg <= shift_n;
      data_in <= data_n;
      valid_data_in <= valid_n;
      busy <= state_n != IDLE;
      frame_err <= fe_n;
      overrun <= ov_n;
    end
  // Flag sets below override the clr_flags defaults, so a same-cycle set wins.
  // A good-frame load overrides the ack default, keeping valid high on ack+load.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shift_n = shift_reg;
    data_n = data_in;
    valid_n = valid_data_in & ~data_ack;
    fe_n = frame_err & ~clr_flags;
    ov_n = overrun & ~clr_flags;
    case (state)
      IDLE: begin
        state_n = (rx_enable && ser_in) ? SHIFT : IDLE;
        cnt_n = '0;
      end
      SHIFT: begin
        state_n = !rx_enable ? IDLE : (cnt == CW'(DATA_W - 1)) ? STOP : SHIFT;
        shift_n = {shift_reg[DATA_W-2:0], ser_in};
        cnt_n = cnt + 1'b1;
      end
      STOP: begin
        state_n = IDLE;
        if (rx_enable) begin
          if (ser_in) fe_n = 1'b1;
          else if (valid_data_in && !data_ack) ov_n = 1'b1;
          else begin
            data_n = shift_reg;
            valid_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ser_input_ctrlr.sv
// tb_ser_input_ctrlr: table vectors, mid-frame corner cases and random frames vs a frame-level model
module tb_ser_input_ctrlr;
  localparam int W = 64;
  logic clk_div_4 = 0, reset_n = 0, ser_in = 0, rx_enable = 1, data_ack = 0, clr_flags = 0;
  logic [W-1:0] data_in;
  logic valid_data_in, busy, frame_err, overrun;
  int total = 0, passed = 0;
  logic [W-1:0] m_data;
  logic m_valid, m_fe, m_ov;

  ser_input_ctrlr #(.DATA_W(W)) dut (
    .clk_div_4(clk_div_4), .reset_n(reset_n), .ser_in(ser_in), .rx_enable(rx_enable),
    .data_ack(data_ack), .clr_flags(clr_flags), .data_in(data_in),
    .valid_data_in(valid_data_in), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk_div_4 = ~clk_div_4;

  typedef struct {
    logic [W-1:0] word;
    logic stop, ack_stop, clr_stop, ack_after, clr_after;
    logic [W-1:0] e_data;
    logic e_valid, e_fe, e_ov;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk_div_4);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic stop, input logic ack_s,
                            input logic clr_s, input int cut, input bit use_rst);
    ser_in = 1;
    cyc();
    chk("busy_start", busy, 1);
    for (int i = 0; i < W; i++) begin
      if (i == cut) begin
        if (use_rst) begin
          chk("busy_before_rst", busy, 1);
          ser_in = 1'($urandom); data_ack = 1'($urandom);
          clr_flags = 1'($urandom); rx_enable = 1'($urandom);
          #2 reset_n = 0;
          #1;
          chk("rst_data", data_in, 0);
          chk("rst_valid", valid_data_in, 0);
          chk("rst_busy", busy, 0);
          chk("rst_fe", frame_err, 0);
          chk("rst_ov", overrun, 0);
          reset_n = 1; ser_in = 0; data_ack = 0; clr_flags = 0; rx_enable = 1;
        end else begin
          rx_enable = 0; ser_in = word[W-1-i];
          cyc();
          chk("abort_busy", busy, 0);
          rx_enable = 1; ser_in = 0;
        end
        return;
      end
      ser_in = word[W-1-i];
      cyc();
    end
    ser_in = stop; data_ack = ack_s; clr_flags = clr_s;
    cyc();
    ser_in = 0; data_ack = 0; clr_flags = 0;
    chk("busy_end", busy, 0);
  endtask

  // Frame-level reference: what one complete frame does to the held word and flags.
  task automatic m_frame(input logic [W-1:0] w, input logic stop, input logic ack, input logic clr);
    if (clr) begin m_fe = 0; m_ov = 0; end
    if (stop) begin
      m_fe = 1;
      if (ack) m_valid = 0;
    end else if (m_valid && !ack) m_ov = 1;
    else begin m_data = w; m_valid = 1; end
  endtask

  task automatic m_gap(input logic ack, input logic clr);
    if (ack) m_valid = 0;
    if (clr) begin m_fe = 0; m_ov = 0; end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_data"}, data_in, m_data);
    chk({tag, "_valid"}, valid_data_in, m_valid);
    chk({tag, "_fe"}, frame_err, m_fe);
    chk({tag, "_ov"}, overrun, m_ov);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    tbl[0] = '{64'hA5A5_0000_FFFF_1234, 0, 0, 0, 1, 0, 64'hA5A5_0000_FFFF_1234, 1, 0, 0};
    tbl[1] = '{64'h0123_4567_89AB_CDEF, 1, 0, 0, 0, 1, 64'hA5A5_0000_FFFF_1234, 0, 1, 0};
    tbl[2] = '{64'h1111_1111_1111_1111, 0, 0, 0, 0, 0, 64'h1111_1111_1111_1111, 1, 0, 0};
    tbl[3] = '{64'h2222_2222_2222_2222, 0, 0, 0, 0, 1, 64'h1111_1111_1111_1111, 1, 0, 1};
    tbl[4] = '{64'hDEAD_BEEF_0000_0001, 0, 1, 0, 1, 0, 64'hDEAD_BEEF_0000_0001, 1, 0, 0};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 0, 1, 64'hDEAD_BEEF_0000_0001, 0, 1, 0};
    tbl[6] = '{64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 0, 0, 0, 64'h0F0F_0F0F_0F0F_0F0F, 1, 0, 0};
    #1;
    chk("init_data", data_in, 0);
    chk("init_valid", valid_data_in, 0);
    chk("init_busy", busy, 0);
    cyc();
    cyc();
    reset_n = 1;
    cyc();
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].word, tbl[i].stop, tbl[i].ack_stop, tbl[i].clr_stop, -1, 0);
      chk($sformatf("t%0d_data", i), data_in, tbl[i].e_data);
      chk($sformatf("t%0d_valid", i), valid_data_in, W'(tbl[i].e_valid));
      chk($sformatf("t%0d_fe", i), frame_err, W'(tbl[i].e_fe));
      chk($sformatf("t%0d_ov", i), overrun, W'(tbl[i].e_ov));
      data_ack = tbl[i].ack_after; clr_flags = tbl[i].clr_after;
      cyc();
      data_ack = 0; clr_flags = 0;
      cyc();
    end
    chk("after_ack_valid", valid_data_in, 1);
    send_frame({$urandom, $urandom}, 0, 0, 0, 30, 1);
    cyc();
    chk("post_rst_busy", busy, 0);
    send_frame(64'h1, 0, 0, 0, -1, 0);
    chk("post_rst_data", data_in, 64'h1);
    chk("post_rst_valid", valid_data_in, 1);
    data_ack = 1;
    cyc();
    data_ack = 0;
    chk("ack_clear", valid_data_in, 0);
    send_frame({$urandom, $urandom}, 0, 0, 0, 30, 0);
    cyc();
    cyc();
    chk("abort_valid", valid_data_in, 0);
    chk("abort_data", data_in, 64'h1);
    chk("abort_fe", frame_err, 0);
    chk("abort_idle", busy, 0);
    m_data = 64'h1; m_valid = 0; m_fe = 0; m_ov = 0;
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] w;
      logic st, ak, cl, ga, gc;
      int gap;
      w = {$urandom, $urandom};
      st = ($urandom_range(0, 7) == 0);
      ak = 1'($urandom);
      cl = ($urandom_range(0, 7) == 0);
      send_frame(w, st, ak, cl, -1, 0);
      m_frame(w, st, ak, cl);
      chk_model($sformatf("r%0d", n));
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        ga = ($urandom_range(0, 3) == 0);
        gc = ($urandom_range(0, 3) == 0);
        data_ack = ga; clr_flags = gc;
        cyc();
        m_gap(ga, gc);
      end
      data_ack = 0; clr_flags = 0;
      chk_model($sformatf("g%0d", n));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ser_input_ctrlr.md
SER_INPUT_CTRLR -- requirements
Module: ser_input_ctrlr

Interface
REQ-001 Parameter DATA_W SHALL be: DATA_W, default 64, received word width in bits.
REQ-002 Port SHALL be: clk_div_4  input  1  sampling clock; all logic on its rising edge.
REQ-003 Port SHALL be: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port SHALL be: ser_in  input  1  serial line, idle low, frames sent MSB first.
REQ-005 Port SHALL be: rx_enable  input  1  1 = start-bit detection allowed.
REQ-006 Port SHALL be: data_ack  input  1  consumer accepts the held word.
REQ-007 Port SHALL be: clr_flags  input  1  synchronous clear of the sticky error flags.
REQ-008 Port SHALL be: data_in  output  DATA_W  last complete received word.
REQ-009 Port SHALL be: valid_data_in  output  1  data_in holds an unacknowledged word.
REQ-010 Port SHALL be: busy  output  1  frame reception in progress (state not IDLE).
REQ-011 Port SHALL be: frame_err  output  1  sticky; a stop bit was sampled as 1.
REQ-012 Port SHALL be: overrun  output  1  sticky; a good word was dropped because the held word was not acknowledged.

Function
REQ-013 Frame SHALL be: start bit (1), DATA_W data bits MSB first, stop bit (0); one bit per clk_div_4 edge; DATA_W+2 cycles total.
REQ-014 FSM SHALL have states IDLE, SHIFT and STOP, with a bit counter of width clog2(DATA_W).
REQ-015 In IDLE, an edge with rx_enable=1 and ser_in=1 SHALL move the FSM to SHIFT with bit counter=0; otherwise the FSM SHALL remain in IDLE.
REQ-016 In SHIFT, each edge SHALL load shift_reg <= {shift_reg[DATA_W-2:0], ser_in} and increment the counter.
REQ-017 The counter reaching DATA_W-1 SHALL move the FSM to STOP after that shift, so that exactly DATA_W bits are captured.
REQ-018 In STOP with ser_in=0 (good frame), data_in SHALL be loaded with shift_reg and valid_data_in set to 1 at that edge, unless an overrun per REQ-021 applies.
REQ-019 In STOP with ser_in=1, frame_err SHALL be set, the word discarded, and data_in/valid_data_in left unchanged.
REQ-020 STOP SHALL always return the FSM to IDLE; the earliest next start bit is sampled on the following edge.
REQ-021 Overrun: on a good frame with valid_data_in=1 and data_ack=0, overrun SHALL be set, the new word dropped, and data_in kept.
REQ-022 Simultaneous events: on a good frame with valid_data_in=1 and data_ack=1, data_in SHALL take the new word, valid_data_in SHALL stay 1, and overrun SHALL NOT be set.
REQ-023 Outside REQ-022, data_ack=1 with valid_data_in=1 SHALL clear valid_data_in at that edge; data_ack with valid_data_in=0 SHALL be ignored.
REQ-024 rx_enable=0 during SHIFT or STOP SHALL abort the frame: the FSM returns to IDLE, the partial word is discarded, and no flag changes.
REQ-025 clr_flags=1 SHALL clear frame_err and overrun; a flag-set event in the same cycle SHALL win (flag ends at 1).
REQ-026 busy SHALL be 1 exactly in SHIFT and STOP.
REQ-027 Latency SHALL be: start bit sampled at edge k, data bits at edges k+1..k+DATA_W, stop bit at edge k+DATA_W+1, valid_data_in high after that edge.
REQ-028 All outputs SHALL be registered; there are no combinational input-to-output paths.

Reset
REQ-029 reset_n=0 SHALL asynchronously force the FSM to IDLE, the counter to 0, shift_reg to 0, data_in to 0, and valid_data_in, busy, frame_err and overrun to 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial word; after release, the next start bit SHALL be received normally.

Verification
REQ-031 Reset: assert reset_n=0 with arbitrary inputs -> all outputs 0 immediately, without a clock edge.
REQ-032 Single frame: send 1, 0xA5A5_0000_FFFF_1234 MSB first, 0 -> data_in=0xA5A5_0000_FFFF_1234, valid_data_in=1 after edge 66 (counting the start bit as edge 1); busy=0; valid_data_in held until data_ack, then cleared next edge.
REQ-033 Frame error: send a frame with stop bit=1 -> frame_err=1, valid_data_in=0, data_in unchanged; then clr_flags=1 -> frame_err=0.
REQ-034 Overrun: send 0x1111_1111_1111_1111 then 0x2222_2222_2222_2222 with no ack -> overrun=1, data_in=0x1111_1111_1111_1111.
REQ-035 Simultaneous ack: hold word A, assert data_ack on the stop-bit edge of word B=0xDEAD_BEEF_0000_0001 -> data_in=B, valid_data_in=1, overrun=0.
REQ-036 Abort and reset mid-frame: drop rx_enable at data bit 30 -> busy=0, no valid_data_in; in a second frame, pulse reset_n at bit 30, then send 0x0000_0000_0000_0001 -> received correctly.
